seven_seg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed hex driver for a common-anode multi-digit 7-segment display; successor to the team's single-digit hex decoder.
- Holds a NUM_DIGITS-wide hex value and scans one digit per refresh slot.
- Adds a ghost-suppression guard, leading-zero blanking, per-digit decimal points, and tear-free value updates applied only at frame boundaries.
- Sits between system status logic and the board display pins.

---
 rtl/seven_seg_scan_driver.sv | 211 +++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver
// Purpose  : Time-multiplexed hex driver for a common-anode multi-digit
//            7-segment display with guard slots, leading-zero blanking,
//            per-digit decimal points and frame-synchronous value updates.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic                    pending,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_idx_w   = $clog2(NUM_DIGITS);
    localparam int c_presc_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [c_idx_w-1:0]    c_last_idx   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_presc_w-1:0]  c_last_presc = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_presc_w-1:0]  c_guard      = c_presc_w'(GUARD_CYCLES);
    localparam logic                  c_seg_pol    = (SEG_ACTIVE_LOW != 0);
    localparam logic                  c_an_pol     = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]            c_seg_off    = {7{c_seg_pol}};
    localparam logic [NUM_DIGITS-1:0] c_an_off     = {NUM_DIGITS{c_an_pol}};
    localparam logic [NUM_DIGITS-1:0] c_one        = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [c_presc_w-1:0]    r_presc;
    logic [c_presc_w-1:0]    w_presc_nx;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_idx_w-1:0]      w_idx_nx;

    logic [4*NUM_DIGITS-1:0] r_act_val;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pending;

    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_boundary;
    logic                    w_xfer;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_nibble;
    logic [6:0]              w_lit;
    logic [NUM_DIGITS-1:0]   w_onehot;

    // Logical lit pattern, bit 6 = segment a ... bit 0 = segment g
    function automatic logic [6:0] hex_lit(input logic [3:0] h);
        logic [6:0] l;
        case (h)
            4'h0:    l = 7'b1111110;
            4'h1:    l = 7'b0110000;
            4'h2:    l = 7'b1101101;
            4'h3:    l = 7'b1111001;
            4'h4:    l = 7'b0110011;
            4'h5:    l = 7'b1011011;
            4'h6:    l = 7'b1011111;
            4'h7:    l = 7'b1110000;
            4'h8:    l = 7'b1111111;
            4'h9:    l = 7'b1111011;
            4'hA:    l = 7'b1110111;
            4'hB:    l = 7'b0011111;
            4'hC:    l = 7'b1001110;
            4'hD:    l = 7'b0111101;
            4'hE:    l = 7'b1001111;
            default: l = 7'b1000111;
        endcase
        return l;
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_idx_nx   = r_idx;
        if (!enable) begin
            w_state_nx = S_IDLE;
            w_presc_nx = '0;
            w_idx_nx   = '0;
        end else begin
            case (r_state)
                S_GUARD, S_DRIVE: begin
                    if (r_presc == c_last_presc) begin
                        w_presc_nx = '0;
                        w_idx_nx   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                    end else begin
                        w_presc_nx = r_presc + 1'b1;
                    end
                    w_state_nx = (w_presc_nx < c_guard) ? S_GUARD : S_DRIVE;
                end
                default: begin
                    w_presc_nx = '0;
                    w_idx_nx   = '0;
                    w_state_nx = (c_guard == '0) ? S_DRIVE : S_GUARD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_idx   <= w_idx_nx;
        end
    end

    assign w_boundary = enable && (r_state != S_IDLE) &&
                        (r_presc == c_last_presc) && (r_idx == c_last_idx);
    // While idle nothing is on screen, so a new value may be adopted at once
    assign w_xfer     = w_boundary || (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_val  <= '0;
            r_act_dp   <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val <= value_in;
                r_pend_dp  <= dp_in;
            end
            if (w_xfer) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_act_val <= value_in;
                    r_act_dp  <= dp_in;
                end else if (r_pending) begin
                    r_act_val <= r_pend_val;
                    r_act_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // A digit is blank when it and every more significant nibble are zero
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run && (r_act_val[4*i +: 4] == 4'h0);
            w_blank[i] = w_zero_run && lz_blank;
        end
    end

    assign w_nibble = 4'(r_act_val >> {r_idx, 2'b00});
    assign w_lit    = w_blank[r_idx] ? 7'b0000000 : hex_lit(w_nibble);
    assign w_onehot = c_one << r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= c_seg_off;
            r_dp         <= c_seg_pol;
            r_an         <= c_an_off;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (enable && (r_state == S_DRIVE)) begin
                r_an  <= w_onehot ^ c_an_off;
                r_seg <= w_lit ^ c_seg_off;
                r_dp  <= r_act_dp[r_idx] ^ c_seg_pol;
            end else begin
                r_an  <= c_an_off;
                r_seg <= c_seg_off;
                r_dp  <= c_seg_pol;
            end
        end
    end

    assign pending    = r_pending;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_driver
// Purpose  : Self-checking bench for seven_seg_scan_driver (4 digits, 8-cycle
//            slots, 2-cycle guard, active-low pins) against a timeline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = ND * DIV;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in    = '0;
    logic        lz_blank = 1'b0;
    logic        load     = 1'b0;
    logic        pending;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (DIV),
        .GUARD_CYCLES   (GRD),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .load       (load),
        .pending    (pending),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [13:0] obs;
    logic [13:0] exp_out;
    assign obs = {pending, frame_done, dp, an, seg};
    localparam logic [13:0] DARK = {1'b0, 1'b0, 1'b1, 4'hF, 7'h7F};

    string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                              "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                              "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Model: m_t counts cycles since scanning began; slot/digit follow by division
    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pending;

    function automatic logic [6:0] seg_mask(input logic [3:0] h);
        string      s;
        logic [6:0] m;
        s = seg_names[h];
        m = '0;
        for (int k = 0; k < s.len(); k++) m[6 - int'(s[k] - 8'h61)] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_act = '0; m_pend = '0;
        m_adp = '0; m_pdp = '0; m_pending = 0;
    endtask

    task automatic tick();
        int         pos, d;
        logic [6:0] lit, e_seg;
        logic [3:0] e_an;
        logic       e_dp;
        bit         bnd;
        @(posedge clk);
        pos   = m_t % DIV;
        d     = (m_t / DIV) % ND;
        e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
        if (enable && m_run && pos >= GRD) begin
            e_an  = ~(4'b0001 << d);
            lit   = (lz_blank && d > 0 && (m_act >> (4 * d)) == 16'h0) ? 7'h00
                                                                       : seg_mask(m_act[4*d +: 4]);
            e_seg = ~lit;
            e_dp  = ~m_adp[d];
        end
        bnd = enable && m_run && (m_t % FRAME) == FRAME - 1;
        if (bnd || !m_run) begin
            if (load) begin m_act = value_in; m_adp = dp_in; end
            else if (m_pending) begin m_act = m_pend; m_adp = m_pdp; end
            m_pending = 0;
        end else if (load) begin
            m_pend = value_in; m_pdp = dp_in; m_pending = 1;
        end
        if (!enable) begin m_run = 0; m_t = 0; end
        else if (!m_run) begin m_run = 1; m_t = 0; end
        else m_t++;
        exp_out = {m_pending, bnd, e_dp, e_an, e_seg};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== DARK) begin
            miscompares++;
            $display("FAIL reset_hold: got %b required %b", obs, DARK);
        end
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL reset_idle @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
    endtask

    task automatic test_basic_scan();
        int fd_count = 0;
        enable = 1'b1; load = 1'b1; value_in = 16'h1234; dp_in = 4'h0; lz_blank = 1'b0;
        for (int c = 0; c < 3 * FRAME + 4; c++) begin
            tick();
            load = 1'b0;
            if (frame_done === 1'b1) fd_count++;
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL basic_scan @%0t: got %b required %b", $time, obs, exp_out);
            end
            if (an === 4'b1110) begin
                vectors++;
                if (seg !== 7'b1001100) begin
                    miscompares++;
                    $display("FAIL digit0_four: got %b required 1001100", seg);
                end
            end
            if (an === 4'b0111) begin
                vectors++;
                if (seg !== 7'b1001111) begin
                    miscompares++;
                    $display("FAIL digit3_one: got %b required 1001111", seg);
                end
            end
        end
        vectors++;
        if (fd_count != 3) begin
            miscompares++;
            $display("FAIL frame_done_count: got %0d required 3", fd_count);
        end
    endtask

    task automatic test_midframe_load();
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < FRAME && (m_t % FRAME) != 10 + r * 9; g++) begin
                tick();
                vectors++;
                if (obs !== exp_out) begin
                    miscompares++;
                    $display("FAIL midframe_align @%0t: got %b required %b", $time, obs, exp_out);
                end
            end
            load = 1'b1;
            value_in = (r == 0) ? 16'hABCD : 16'($urandom);
            dp_in = 4'($urandom);
            tick();
            load = 1'b0;
            vectors++;
            if (pending !== 1'b1) begin
                miscompares++;
                $display("FAIL midframe_pending: got %b required 1", pending);
            end
            for (int c = 0; c < 2 * FRAME; c++) begin
                tick();
                vectors++;
                if (obs !== exp_out) begin
                    miscompares++;
                    $display("FAIL midframe_load @%0t: got %b required %b", $time, obs, exp_out);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [6];
        logic [3:0]  dps  [6];
        vals[0] = 16'h0070; dps[0] = 4'b0100;
        vals[1] = 16'h0000; dps[1] = 4'b0000;
        for (int i = 2; i < 6; i++) begin
            vals[i] = 16'($urandom) & {{4{1'($urandom)}}, {4{1'($urandom)}}, {4{1'($urandom)}}, 4'hF};
            dps[i]  = 4'($urandom);
        end
        lz_blank = 1'b1;
        for (int v = 0; v < 6; v++) begin
            load = 1'b1; value_in = vals[v]; dp_in = dps[v];
            for (int c = 0; c < 2 * FRAME + 3; c++) begin
                tick();
                load = 1'b0;
                vectors++;
                if (obs !== exp_out) begin
                    miscompares++;
                    $display("FAIL lz_blank v=%h @%0t: got %b required %b", vals[v], $time, obs, exp_out);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; value_in = 16'h1111; dp_in = 4'h1;
        tick();
        vectors++;
        if (obs !== exp_out) begin
            miscompares++;
            $display("FAIL b2b_first @%0t: got %b required %b", $time, obs, exp_out);
        end
        value_in = 16'h2222; dp_in = 4'h2;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            load = 1'b0;
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL b2b_last_wins @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
        for (int g = 0; g < 2 * FRAME && !(m_run && (m_t % FRAME) == FRAME - 1); g++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL b2b_align @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
        load = 1'b1; value_in = 16'($urandom); dp_in = 4'($urandom);
        tick();
        load = 1'b0;
        vectors++;
        if (pending !== 1'b0 || frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL boundary_load: got pending=%b frame_done=%b required 0/1", pending, frame_done);
        end
        for (int c = 0; c < FRAME + 2; c++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL boundary_frame @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
    endtask

    task automatic test_enable_drop();
        for (int g = 0; g < 2 * FRAME && (m_t % FRAME) != 2 * DIV + 4; g++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL drop_align @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
        enable = 1'b0;
        tick();
        vectors++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            miscompares++;
            $display("FAIL drop_dark: got an=%b seg=%b required 1111/1111111", an, seg);
        end
        load = 1'b1; value_in = 16'($urandom); dp_in = 4'($urandom);
        for (int c = 0; c < 4; c++) begin
            tick();
            load = 1'b0;
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL drop_idle @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL reenable @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; value_in = 16'h5A5A; dp_in = 4'hF;
        tick();
        load = 1'b0;
        for (int g = 0; g < 2 * DIV && (m_t % DIV) != 5; g++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL areset_align @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 7'h7F || pending !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got an=%b seg=%b pending=%b required 1111/1111111/0", an, seg, pending);
        end
        enable = 1'b0;
        model_reset();
        #1;
        rst = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL post_reset @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            enable   = ($urandom_range(0, 59) != 0);
            load     = ($urandom_range(0, 14) == 0);
            value_in = 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'h00FF : 16'hFFFF);
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
            tick();
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL random @%0t: got %b required %b", $time, obs, exp_out);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_scan();
        test_midframe_load();
        test_lz_blank();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
